zrb_uart_rx_os8: RTL and testbench
==================================

# zrb_uart_rx_os8

8N1 UART receiver that pairs with `zrb_uart_tx`: data LSB first, one start bit, one stop bit. It runs on the system clock with an internal 8× oversampling tick and takes a 3-sample majority vote near each bit centre. It reports framing errors and overruns, and hands each byte to the consumer through a valid/ready handshake. It sits between the board RX pin and the RX FIFO or command parser.

## Interface
- `CLK_HZ`, 50000000: system clock frequency.
- `BAUD`, 9600: line rate.
- `DIV`, `CLK_HZ/(8*BAUD)` (integer division): clocks per oversample tick. Must be ≥2; elaboration fails otherwise.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rx`  in  1: raw serial line, asynchronous to `clk`, idles high.
- `data_out`  out  8: last good byte; stable while `data_valid`=1.
- `data_valid`  out  1: byte available; held until consumed.
- `data_ready`  in  1: consumer accepts; transfer occurs when `data_valid & data_ready`.
- `frame_err`  out  1: one-cycle pulse when the stop bit samples low.
- `overrun`  out  1: one-cycle pulse when a good frame completes while an unconsumed byte is held.
- `busy`  out  1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-FF synchroniser (both FFs reset to 1). The edge detector compares the synchroniser output with its previous value.
- States:
  - IDLE → START on a synchronised falling edge (1→0). Entering START clears the tick divider and the tick index.
  - Divider counts 0..DIV-1 and pulses `tick` on DIV-1. Tick index t counts ticks from 0.
  - Bit number = t/8 (0 = start, 1..8 = data, 9 = stop). Sample number s = t mod 8.
  - Samples are taken at s = 3, 4, 5; majority of the three gives the bit value.
- START: at s=7, a majority of 0 → DATA; a majority of 1 is a false start → IDLE with no outputs touched.
- DATA: at s=7, shift the majority bit into the MSB of the shift register (LSB-first arrival). After the 8th data bit → STOP.
- STOP: decide at s=5 (mid-stop), then → IDLE immediately so the next start edge can be detected.
  - Majority 1 and `data_valid`=0, or `data_ready`=1 this cycle: load `data_out`, set `data_valid`.
  - Majority 1, `data_valid`=1 and `data_ready`=0: pulse `overrun`; the new byte is dropped and `data_out` is unchanged.
  - Majority 0: pulse `frame_err`; byte discarded; `data_valid` and `data_out` unaffected.
- Handshake: `data_valid` clears on the cycle after `valid & ready`, unless a new byte loads in that same cycle, in which case it stays 1.
- The falling-edge detector is ignored outside IDLE.
- Reset (asynchronous, any time, including mid-frame): state IDLE, synchroniser 11, divider/counters 0, `data_out`=0, `data_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.

## Timing
- E = cycle in which the synchronised `rx` first reads 0. START is registered at E+1 with the divider at 0.
- Tick t occurs in cycle E+(t+1)·DIV. Sample centre of bit n ≈ E+(8n+5)·DIV.
- Stop decision at t=77, i.e. cycle E+78·DIV. `data_valid`, `frame_err` or `overrun` is visible at E+78·DIV+1.
- Pin-to-E latency: 2 cycles.
- `busy` rises at E+1 and falls together with the stop-decision update.
- Baud error budget: ±3% total. Divider rounding is the integrator's responsibility.

## Structure
- Shared `zrb_uart_pkg`:
  - state encoding (IDLE, START, DATA, STOP);
  - `OS`=8 and sample positions 3/4/5;
  - a `uart_div(clk_hz, baud)` function, also used by the TX side.
- Sub-module `zrb_uart_tick_gen`: divider with synchronous clear and `tick` output, parameter DIV.
- The FSM, synchroniser, majority vote and handshake stay in the top module.

## Test plan
Common setup: CLK_HZ=1228800, BAUD=38400, so DIV=4 and a bit is 32 cycles.

1. Frame 0xA5, 8N1, `data_ready`=0 → `data_out`=0xA5, `data_valid` rises at E+313, `frame_err`=0.
2. `rx` low for 8 cycles, then high (false start) → no `data_valid`; `busy` high from E+1 and low by E+33; a following 0x3C frame is received correctly.
3. Frame 0x3C with stop bit forced 0 → `frame_err` 1-cycle pulse at E+313; `data_valid` stays 0; `data_out` unchanged.
4. Back-to-back 0x11 then 0x22 with `data_ready`=0 → `data_out`=0x11 held; `overrun` pulses at the second frame's decision. Then `data_ready`=1 for one cycle → `data_valid`=0 on the next cycle.
5. `data_ready` pulsed in exactly the stop-decision cycle of 0x22 while 0x11 is held → `data_out`=0x22, `data_valid` stays 1, `overrun`=0. A 1-cycle glitch at s=4 of any data bit does not change the received value.
6. `reset_n` low during data bit 4 → all outputs 0 asynchronously and `busy`=0. After release, a 0x5A frame yields `data_out`=0x5A with no errors.

Source files
------------

// File: rtl/zrb_uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and the
// baud divider helper used by both the receive and transmit sides.
package zrb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int OS = 8;

  // Sub-bit positions within one bit period (tick index mod 8).
  localparam logic [2:0] SMP_FIRST  = 3'd3;
  localparam logic [2:0] SMP_MID    = 3'd4;
  localparam logic [2:0] SMP_LAST   = 3'd5;
  localparam logic [2:0] SMP_DECIDE = 3'd7;

  localparam logic [3:0] LAST_DATA_BIT = 4'd8;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / (OS * baud);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/zrb_uart_tick_gen.sv
// Oversample tick divider: counts 0..DIV-1 and pulses tick on the last count.
// A synchronous clear holds the count at zero so a frame starts phase-aligned.
module zrb_uart_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/zrb_uart_rx_os8.sv
// 8N1 UART receiver with 8x oversampling and 3-sample majority vote; hands
// bytes to the consumer over valid/ready and flags framing errors and overruns.
module zrb_uart_rx_os8
  import zrb_uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600,
  parameter int DIV    = uart_div(CLK_HZ, BAUD)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  if (DIV < 2) begin : g_bad_div
    $error("zrb_uart_rx_os8: DIV must be at least 2");
  end

  uart_state_t state;
  logic        sync1;
  logic        sync2;
  logic        rx_prev;
  logic        fall_edge;
  logic        tick;
  logic        clear;
  logic [6:0]  tick_idx;
  logic [2:0]  sub;
  logic [3:0]  bit_num;
  logic [1:0]  samples;
  logic        bit_val;
  logic        vote;
  logic [7:0]  shift_reg;

  assign sub       = tick_idx[2:0];
  assign bit_num   = tick_idx[6:3];
  assign fall_edge = rx_prev & ~sync2;
  assign clear     = (state == IDLE);
  assign vote      = maj3(samples[0], samples[1], sync2);

  zrb_uart_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .tick   (tick)
  );

  // Two-stage synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_idx  <= '0;
      samples   <= '0;
      bit_val   <= 1'b0;
      shift_reg <= '0;
    end else if (state == IDLE) begin
      tick_idx <= '0;
    end else if (tick) begin
      tick_idx <= tick_idx + 7'd1;
      if (sub == SMP_FIRST) samples[0] <= sync2;
      if (sub == SMP_MID)   samples[1] <= sync2;
      if (sub == SMP_LAST)  bit_val    <= vote;
      if (state == DATA && sub == SMP_DECIDE) shift_reg <= {bit_val, shift_reg[7:1]};
    end
  end

  // The stop decision is taken at mid-stop so the next start edge is never missed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall_edge) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick && sub == SMP_DECIDE) begin
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick && sub == SMP_DECIDE && bit_num == LAST_DATA_BIT) state <= STOP;
        end
        STOP: begin
          if (tick && sub == SMP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!vote) begin
              frame_err <= 1'b1;
            end else if (!data_valid || data_ready) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zrb_uart_rx_os8.sv
// Directed bench for zrb_uart_rx_os8 at DIV=4 (32 clocks per bit); expected
// event cycles are derived from the start-bit cycle E = pin cycle + 2.
module tb_zrb_uart_rx_os8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;

  int dv_rise_cyc = -1;
  int dv_rise_count = 0;
  int dv_fall_count = 0;
  int fe_cyc = -1;
  int fe_count = 0;
  int ov_cyc = -1;
  int ov_count = 0;
  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  logic dv_prev = 1'b0;
  logic busy_prev = 1'b0;

  zrb_uart_rx_os8 #(
    .CLK_HZ(1228800),
    .BAUD  (38400)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (data_valid && !dv_prev) begin
      dv_rise_cyc = cyc;
      dv_rise_count++;
    end
    if (!data_valid && dv_prev) dv_fall_count++;
    if (frame_err) begin
      fe_cyc = cyc;
      fe_count++;
    end
    if (overrun) begin
      ov_cyc = cyc;
      ov_count++;
    end
    if (busy && !busy_prev) busy_rise_cyc = cyc;
    if (!busy && busy_prev) busy_fall_cyc = cyc;
    dv_prev   = data_valid;
    busy_prev = busy;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
             tag, observed, observed, expected, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 10-bit frame, 32 clocks per bit. Optional: glitch at s=4 of a
  // data bit, data_ready pulse at frame offset ready_at, reset at reset_at.
  task automatic apply_stimulus(input logic [7:0] value, input logic stop_bit,
                                input int glitch_bit, input int ready_at,
                                input int reset_at);
    logic [9:0] frame;
    frame = {stop_bit, value, 1'b0};
    for (int j = 0; j < 320; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) start_cyc = cyc;
      if (j == reset_at) begin
        rx = 1'b1;
        data_ready = 1'b0;
        reset_n = 1'b0;
        #2;
        return;
      end
      rx = frame[j / 32];
      if (glitch_bit >= 0 && j == 32 * (glitch_bit + 1) + 20) rx = ~rx;
      data_ready = (j == ready_at);
    end
  endtask

  task automatic consume();
    @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk);
    #1 data_ready = 1'b0;
  endtask

  initial begin
    int e;
    int saved_fe;
    int saved_ov;
    int saved_dv;
    int saved_fall;

    $display("[TB] zrb_uart_rx_os8 directed test start");
    wait_cycles(3);
    check_output("reset data_out", data_out, 8'h00);
    check_output("reset data_valid", data_valid, 0);
    check_output("reset busy", busy, 0);
    check_output("reset frame_err", frame_err, 0);
    check_output("reset overrun", overrun, 0);
    reset_n = 1'b1;
    wait_cycles(5);

    // Test 1: plain 0xA5 frame, consumer not ready.
    apply_stimulus(8'hA5, 1'b1, -1, -1, -1);
    e = start_cyc + 2;
    wait_cycles(4);
    check_output("t1 data_valid rise cycle", dv_rise_cyc, e + 313);
    check_output("t1 busy rise cycle", busy_rise_cyc, e + 1);
    check_output("t1 busy fall cycle", busy_fall_cyc, e + 313);
    check_output("t1 data_out", data_out, 8'hA5);
    check_output("t1 data_valid", data_valid, 1);
    check_output("t1 frame_err count", fe_count, 0);
    consume();
    check_output("t1 data_valid after ready", data_valid, 0);

    // Test 2: 8-cycle low pulse is a false start, then a real 0x3C frame.
    saved_dv = dv_rise_count;
    @(posedge clk);
    #1 rx = 1'b0;
    e = cyc + 2;
    wait_cycles(8);
    rx = 1'b1;
    wait_cycles(50);
    check_output("t2 busy rise cycle", busy_rise_cyc, e + 1);
    check_output("t2 busy fall cycle", busy_fall_cyc, e + 33);
    check_output("t2 no data_valid", dv_rise_count, saved_dv);
    check_output("t2 data_valid low", data_valid, 0);
    apply_stimulus(8'h3C, 1'b1, -1, -1, -1);
    e = start_cyc + 2;
    wait_cycles(4);
    check_output("t2 data_valid rise cycle", dv_rise_cyc, e + 313);
    check_output("t2 data_out", data_out, 8'h3C);
    consume();
    check_output("t2 data_valid after ready", data_valid, 0);

    // Test 3: stop bit forced low gives a framing error only.
    saved_fe = fe_count;
    saved_dv = dv_rise_count;
    apply_stimulus(8'h3C, 1'b0, -1, -1, -1);
    e = start_cyc + 2;
    rx = 1'b1;
    wait_cycles(8);
    check_output("t3 frame_err cycle", fe_cyc, e + 313);
    check_output("t3 frame_err one pulse", fe_count, saved_fe + 1);
    check_output("t3 data_valid low", data_valid, 0);
    check_output("t3 no data_valid rise", dv_rise_count, saved_dv);
    check_output("t3 data_out kept", data_out, 8'h3C);

    // Test 4: back-to-back 0x11, 0x22 with nobody consuming.
    saved_ov = ov_count;
    apply_stimulus(8'h11, 1'b1, -1, -1, -1);
    apply_stimulus(8'h22, 1'b1, -1, -1, -1);
    e = start_cyc + 2;
    wait_cycles(4);
    check_output("t4 overrun cycle", ov_cyc, e + 313);
    check_output("t4 overrun one pulse", ov_count, saved_ov + 1);
    check_output("t4 data_out held", data_out, 8'h11);
    check_output("t4 data_valid held", data_valid, 1);
    consume();
    check_output("t4 data_valid after ready", data_valid, 0);

    // Test 5: ready in the stop-decision cycle, glitches at s=4 of data bits.
    apply_stimulus(8'h11, 1'b1, 0, -1, -1);
    wait_cycles(4);
    check_output("t5 glitched 0x11", data_out, 8'h11);
    saved_ov   = ov_count;
    saved_fe   = fe_count;
    saved_fall = dv_fall_count;
    apply_stimulus(8'h22, 1'b1, 3, 314, -1);
    wait_cycles(4);
    check_output("t5 data_out replaced", data_out, 8'h22);
    check_output("t5 data_valid stays", data_valid, 1);
    check_output("t5 data_valid never dropped", dv_fall_count, saved_fall);
    check_output("t5 no overrun", ov_count, saved_ov);
    check_output("t5 no frame_err", fe_count, saved_fe);

    // Test 6: reset during data bit 4, then a clean 0x5A frame.
    apply_stimulus(8'h5A, 1'b1, -1, -1, 170);
    check_output("t6 async data_out", data_out, 8'h00);
    check_output("t6 async data_valid", data_valid, 0);
    check_output("t6 async busy", busy, 0);
    check_output("t6 async frame_err", frame_err, 0);
    check_output("t6 async overrun", overrun, 0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(5);
    saved_ov = ov_count;
    saved_fe = fe_count;
    apply_stimulus(8'h5A, 1'b1, -1, -1, -1);
    e = start_cyc + 2;
    wait_cycles(4);
    check_output("t6 data_valid rise cycle", dv_rise_cyc, e + 313);
    check_output("t6 data_out", data_out, 8'h5A);
    check_output("t6 data_valid", data_valid, 1);
    check_output("t6 no overrun", ov_count, saved_ov);
    check_output("t6 no frame_err", fe_count, saved_fe);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
